// File: rtl/datapath_pkg.sv
// Opcode constants and FSM state encoding shared by the parametrised multicycle datapath.
package datapath_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_MEM   = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_param.sv
// Register file: two combinational read ports, one synchronous write port, sync reset to zero.
module regfile_param #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra_addr,
  input  logic [RA_W-1:0]   rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int NREGS = 2 ** RA_W;

  logic [DATA_W-1:0] regs [NREGS];

  // Reads see the pre-write value, so rd == rs uses the old operand.
  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/datapath_param.sv
// Multicycle datapath for the add/lw/sw/jump ISA with a valid/request fetch handshake.
// Handshake: instr_req is high in FETCH; an instruction is consumed on any edge where instr_req && instr_valid.
module datapath_param
  import datapath_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RA_W    = 2,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 4,
  localparam int INSTR_W = 2 + 3 * RA_W
) (
  input  logic               _CLK,
  input  logic               RESET,
  input  logic               run,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  output logic               instr_req,
  output logic [PC_W-1:0]    PC,
  output logic [DATA_W-1:0]  wb_data,
  output logic               wb_valid,
  output logic               retired,
  output state_t             state
);

  localparam int OFF_W  = INSTR_W - 2;
  localparam int JMP_W  = (OFF_W > PC_W) ? OFF_W : PC_W;
  localparam int EA_W   = (DATA_W > DMEM_AW) ? DATA_W : DMEM_AW;
  localparam int DMEM_D = 2 ** DMEM_AW;

  logic [INSTR_W-1:0] ir;
  logic [DMEM_AW-1:0] addr;
  logic [DATA_W-1:0]  mem [DMEM_D];

  logic [1:0]        op;
  logic [RA_W-1:0]   rs, rt, rd;
  logic [DATA_W-1:0] rs_val, rt_val, alu_sum;
  logic [EA_W-1:0]   ea_base, ea_off, ea_sum;
  logic [JMP_W-1:0]  jmp_off;
  logic [PC_W-1:0]   pc_jump;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign op = ir[INSTR_W-1 -: 2];
  assign rs = ir[INSTR_W-3 -: RA_W];
  assign rt = ir[INSTR_W-3-RA_W -: RA_W];
  assign rd = ir[RA_W-1:0];

  assign alu_sum = rs_val + rt_val;

  // Effective address: base + sign-extended imm, reduced modulo the memory depth.
  assign ea_base = EA_W'(rs_val);
  assign ea_off  = EA_W'($signed(rd));
  assign ea_sum  = ea_base + ea_off;

  // PC has already been incremented by the time EXEC computes the jump target.
  assign jmp_off = JMP_W'($signed(ir[OFF_W-1:0]));
  assign pc_jump = PC + jmp_off[PC_W-1:0];

  assign rf_we    = ((state == ST_EXEC) && (op == OP_ADD)) ||
                    ((state == ST_MEM)  && (op == OP_LW));
  assign rf_waddr = (op == OP_ADD) ? rd : rt;
  assign rf_wdata = (op == OP_ADD) ? alu_sum : mem[addr];

  regfile_param #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) u_regfile (
    .clk     (_CLK),
    .rst     (RESET),
    .ra_addr (rs),
    .rb_addr (rt),
    .ra_data (rs_val),
    .rb_data (rt_val),
    .we      (rf_we),
    .wr_addr (rf_waddr),
    .wr_data (rf_wdata)
  );

  always_ff @(posedge _CLK) begin
    if (RESET) begin
      for (int i = 0; i < DMEM_D; i++) mem[i] <= DATA_W'(i);
    end else if ((state == ST_MEM) && (op == OP_SW)) begin
      mem[addr] <= rt_val;
    end
  end

  always_ff @(posedge _CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      PC        <= '0;
      ir        <= '0;
      addr      <= '0;
      instr_req <= 1'b0;
      wb_data   <= '0;
      wb_valid  <= 1'b0;
      retired   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      retired  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state     <= ST_FETCH;
            instr_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (instr_valid) begin
            ir        <= instruction;
            PC        <= PC + PC_W'(1);
            state     <= ST_EXEC;
            instr_req <= 1'b0;
          end
        end
        ST_EXEC: begin
          case (op)
            OP_ADD: begin
              wb_data   <= alu_sum;
              wb_valid  <= 1'b1;
              retired   <= 1'b1;
              state     <= run ? ST_FETCH : ST_IDLE;
              instr_req <= run;
            end
            OP_JMP: begin
              PC        <= pc_jump;
              retired   <= 1'b1;
              state     <= run ? ST_FETCH : ST_IDLE;
              instr_req <= run;
            end
            default: begin
              addr  <= ea_sum[DMEM_AW-1:0];
              state <= ST_MEM;
            end
          endcase
        end
        ST_MEM: begin
          wb_data   <= (op == OP_LW) ? mem[addr] : rt_val;
          wb_valid  <= 1'b1;
          retired   <= 1'b1;
          state     <= run ? ST_FETCH : ST_IDLE;
          instr_req <= run;
        end
        default: begin
          state     <= ST_IDLE;
          instr_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
